// File: rtl/shift_pkg.sv
// shift_pkg: shared constants for the pipelined barrel shifter.
// Op encodings, op field positions and the shift-amount width helper.
package shift_pkg;

    // Field positions inside the [0:2] op vector
    localparam int OP_RIGHT = 0;
    localparam int OP_ARITH = 1;
    localparam int OP_ROT   = 2;

    localparam logic [0:2] SH_SLL = 3'b000;
    localparam logic [0:2] SH_SRL = 3'b100;
    localparam logic [0:2] SH_SRA = 3'b110;
    localparam logic [0:2] SH_ROL = 3'b001;
    localparam logic [0:2] SH_ROR = 3'b101;

    // Number of shift-amount bits (log2) for a power-of-two width
    function automatic int shamt_width(input int width);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < width) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one conditional shift/rotate level of DIST bits with an
// optional valid/ready register behind it.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIST    = 16,
    parameter int SHAMT_W = 5,
    parameter int SEL     = 0,
    parameter int TAG_W   = 4,
    parameter bit REG     = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [0:WIDTH-1]   data_i,
    input  logic               cout_i,
    input  logic               fill_i,
    input  logic [0:2]         op_i,
    input  logic [0:SHAMT_W-1] shamt_i,
    input  logic [0:TAG_W-1]   tag_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [0:WIDTH-1]   data_o,
    output logic               cout_o,
    output logic               fill_o,
    output logic [0:2]         op_o,
    output logic [0:SHAMT_W-1] shamt_o,
    output logic [0:TAG_W-1]   tag_o
);

    logic [0:WIDTH-1] sh_data;
    logic             sh_cout;

    // Apply this level when its shift-amount bit is set; track last bit out
    always_comb begin
        sh_data = data_i;
        sh_cout = cout_i;
        if (shamt_i[SEL]) begin
            unique case ({op_i[OP_ROT], op_i[OP_RIGHT]})
                2'b00: begin
                    sh_data = data_i << DIST;
                    sh_cout = data_i[DIST-1];
                end
                2'b01: begin
                    sh_data = (data_i >> DIST)
                            | ({WIDTH{fill_i}} << (WIDTH - DIST));
                    sh_cout = data_i[WIDTH-DIST];
                end
                2'b10: begin
                    sh_data = (data_i << DIST)
                            | (data_i >> (WIDTH - DIST));
                    sh_cout = 1'b0;
                end
                default: begin
                    sh_data = (data_i >> DIST)
                            | (data_i << (WIDTH - DIST));
                    sh_cout = 1'b0;
                end
            endcase
        end
    end

    if (REG) begin : g_reg
        logic               v_q, v_d;
        logic [0:WIDTH-1]   data_q, data_d;
        logic               cout_q, cout_d;
        logic               fill_q, fill_d;
        logic [0:2]         op_q, op_d;
        logic [0:SHAMT_W-1] shamt_q, shamt_d;
        logic [0:TAG_W-1]   tag_q, tag_d;

        assign ready_o = !v_q || ready_i;

        // Load whenever empty or the current entry moves on downstream
        always_comb begin
            v_d     = v_q;
            data_d  = data_q;
            cout_d  = cout_q;
            fill_d  = fill_q;
            op_d    = op_q;
            shamt_d = shamt_q;
            tag_d   = tag_q;
            if (ready_o) begin
                v_d = valid_i;
                if (valid_i) begin
                    data_d  = sh_data;
                    cout_d  = sh_cout;
                    fill_d  = fill_i;
                    op_d    = op_i;
                    shamt_d = shamt_i;
                    tag_d   = tag_i;
                end
            end
        end

        // Stage register with synchronous clear of all state
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                v_q     <= 1'b0;
                data_q  <= '0;
                cout_q  <= 1'b0;
                fill_q  <= 1'b0;
                op_q    <= '0;
                shamt_q <= '0;
                tag_q   <= '0;
            end else begin
                v_q     <= v_d;
                data_q  <= data_d;
                cout_q  <= cout_d;
                fill_q  <= fill_d;
                op_q    <= op_d;
                shamt_q <= shamt_d;
                tag_q   <= tag_d;
            end
        end

        assign valid_o = v_q;
        assign data_o  = data_q;
        assign cout_o  = cout_q;
        assign fill_o  = fill_q;
        assign op_o    = op_q;
        assign shamt_o = shamt_q;
        assign tag_o   = tag_q;
    end else begin : g_comb
        logic unused_clk;

        assign unused_clk = clk_i ^ rst_i;
        assign ready_o    = ready_i;
        assign valid_o    = valid_i;
        assign data_o     = sh_data;
        assign cout_o     = sh_cout;
        assign fill_o     = fill_i;
        assign op_o       = op_i;
        assign shamt_o    = shamt_i;
        assign tag_o      = tag_i;
    end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter with rotate, carry-out and tag,
// valid/ready on both sides; one shift_stage per shift-amount bit.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int  WIDTH   = 32,
    parameter int  PIPE    = 1,
    parameter int  TAG_W   = 4,
    localparam int SHAMT_W = shamt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:WIDTH-1]   in_a,
    input  logic [0:SHAMT_W-1] in_shamt,
    input  logic [0:2]         in_op,
    input  logic [0:TAG_W-1]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:WIDTH-1]   out_data,
    output logic               out_cout,
    output logic [0:TAG_W-1]   out_tag
);

    localparam int NS = SHAMT_W;

    logic               v_w [NS+1];
    logic               r_w [NS+1];
    logic [0:WIDTH-1]   d_w [NS+1];
    logic               c_w [NS+1];
    logic               f_w [NS+1];
    logic [0:2]         o_w [NS+1];
    logic [0:SHAMT_W-1] s_w [NS+1];
    logic [0:TAG_W-1]   t_w [NS+1];
    logic               unused_tail;

    // Sign fill is decided once at entry from the original operand MSB
    assign v_w[0] = in_valid;
    assign d_w[0] = in_a;
    assign c_w[0] = 1'b0;
    assign f_w[0] = in_a[0] & in_op[OP_RIGHT]
                  & in_op[OP_ARITH] & ~in_op[OP_ROT];
    assign o_w[0] = in_op;
    assign s_w[0] = in_shamt;
    assign t_w[0] = in_tag;
    assign in_ready = r_w[0];

    assign r_w[NS]   = out_ready;
    assign out_valid = v_w[NS];
    assign out_data  = d_w[NS];
    assign out_cout  = c_w[NS];
    assign out_tag   = t_w[NS];

    assign unused_tail = ^{f_w[NS], o_w[NS], s_w[NS]};

    // Largest distance first; the last level always carries a register
    for (genvar k = 0; k < NS; k++) begin : g_lvl
        shift_stage #(
            .WIDTH  (WIDTH),
            .DIST   (1 << (NS - 1 - k)),
            .SHAMT_W(SHAMT_W),
            .SEL    (k),
            .TAG_W  (TAG_W),
            .REG    ((PIPE != 0) || (k == NS - 1))
        ) u_stage (
            .clk_i  (clk),
            .rst_i  (rst),
            .valid_i(v_w[k]),
            .ready_o(r_w[k]),
            .data_i (d_w[k]),
            .cout_i (c_w[k]),
            .fill_i (f_w[k]),
            .op_i   (o_w[k]),
            .shamt_i(s_w[k]),
            .tag_i  (t_w[k]),
            .valid_o(v_w[k+1]),
            .ready_i(r_w[k+1]),
            .data_o (d_w[k+1]),
            .cout_o (c_w[k+1]),
            .fill_o (f_w[k+1]),
            .op_o   (o_w[k+1]),
            .shamt_o(s_w[k+1]),
            .tag_o  (t_w[k+1])
        );
    end

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe with a 32-bit pipelined
// instance and an 8-bit single-register instance.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int NDUT = 2;

    typedef struct packed {
        logic [63:0] dat;
        logic        co;
        logic [3:0]  tag;
        int          cyc;
        logic        lat;
    } item_t;

    typedef struct packed {
        logic        iv;
        logic        ir;
        logic        ov;
        logic        ordy;
        logic        co;
        logic [63:0] dat;
        logic [3:0]  tag;
    } obs_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] a;
        int          n;
        logic [63:0] r;
        logic        c;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic        a_iv, a_ir, a_ov, a_or, a_co;
    logic [31:0] a_a, a_od;
    logic [4:0]  a_sh;
    logic [2:0]  a_op;
    logic [3:0]  a_tg, a_ot;

    logic        b_iv, b_ir, b_ov, b_or, b_co;
    logic [7:0]  b_a, b_od;
    logic [2:0]  b_sh;
    logic [2:0]  b_op;
    logic [3:0]  b_tg, b_ot;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(32), .PIPE(1), .TAG_W(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_iv), .in_ready(a_ir), .in_a(a_a),
        .in_shamt(a_sh), .in_op(a_op), .in_tag(a_tg),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .out_cout(a_co), .out_tag(a_ot)
    );

    shift_pipe #(.WIDTH(8), .PIPE(0), .TAG_W(4)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_iv), .in_ready(b_ir), .in_a(b_a),
        .in_shamt(b_sh), .in_op(b_op), .in_tag(b_tg),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .out_cout(b_co), .out_tag(b_ot)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    item_t q0[$];
    item_t q1[$];
    item_t pend [NDUT];
    obs_t  held [NDUT];
    bit    hold_v [NDUT];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wid(int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 5 : 1;
    endfunction

    function automatic void check(bit ok, string name,
                                  logic [63:0] act, logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void qpush(int d, item_t it);
        if (d == 0) q0.push_back(it);
        else q1.push_back(it);
    endfunction

    function automatic item_t qpop(int d);
        if (d == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qclear(int d);
        if (d == 0) q0.delete();
        else q1.delete();
    endfunction

    function automatic obs_t obs(int d);
        obs_t o;
        if (d == 0) begin
            o = '{iv: a_iv, ir: a_ir, ov: a_ov, ordy: a_or, co: a_co,
                  dat: {32'd0, a_od}, tag: a_ot};
        end else begin
            o = '{iv: b_iv, ir: b_ir, ov: b_ov, ordy: b_or, co: b_co,
                  dat: {56'd0, b_od}, tag: b_ot};
        end
        return o;
    endfunction

    // Reference: whole-operand arithmetic straight from the op rules
    function automatic item_t model(int w, logic [63:0] a, int n,
                                    logic [2:0] op, logic [3:0] tag);
        logic [63:0] m, r;
        logic        c;
        item_t       it;
        m = (64'd1 << w) - 64'd1;
        a = a & m;
        r = a;
        c = 1'b0;
        if (n != 0) begin
            if (op[0]) begin
                if (op[2]) r = ((a >> n) | (a << (w - n))) & m;
                else r = ((a << n) | (a >> (w - n))) & m;
            end else if (op[2]) begin
                r = a >> n;
                if (op[1] && a[w-1]) r = r | (m & ~(m >> n));
                c = a[n-1];
            end else begin
                r = (a << n) & m;
                c = a[w-n];
            end
        end
        it = '{dat: r, co: c, tag: tag, cyc: 0, lat: 1'b0};
        return it;
    endfunction

    function automatic vec_t dir_vec(int d, int i);
        vec_t v;
        v = '0;
        if (d == 0) begin
            case (i)
                0:  v = '{SH_SLL, 64'h1, 31, 64'h8000_0000, 1'b0};
                1:  v = '{SH_SRA, 64'h8000_0000, 4, 64'hF800_0000, 1'b0};
                2:  v = '{SH_SRL, 64'h8000_0000, 4, 64'h0800_0000, 1'b0};
                3:  v = '{SH_ROR, 64'hF1, 4, 64'h1000_000F, 1'b0};
                4:  v = '{SH_ROL, 64'h8000_0001, 1, 64'h3, 1'b0};
                5:  v = '{SH_SRL, 64'h10, 5, 64'h0, 1'b1};
                6:  v = '{SH_SLL, 64'hDEAD_BEEF, 0, 64'hDEAD_BEEF, 1'b0};
                7:  v = '{SH_SRA, 64'hDEAD_BEEF, 0, 64'hDEAD_BEEF, 1'b0};
                8:  v = '{SH_ROR, 64'h1234_5678, 0, 64'h1234_5678, 1'b0};
                9:  v = '{3'b010, 64'hC000_0001, 1, 64'h8000_0002, 1'b1};
                10: v = '{3'b111, 64'h1, 1, 64'h8000_0000, 1'b0};
                11: v = '{3'b011, 64'h8000_0000, 31, 64'h4000_0000, 1'b0};
                default: v = '{SH_SLL, 64'h4000_0000, 2, 64'h0, 1'b1};
            endcase
        end else begin
            case (i)
                0:  v = '{SH_SLL, 64'h01, 7, 64'h80, 1'b0};
                1:  v = '{SH_SRA, 64'h80, 4, 64'hF8, 1'b0};
                2:  v = '{SH_SRL, 64'h80, 4, 64'h08, 1'b0};
                3:  v = '{SH_ROR, 64'hF1, 4, 64'h1F, 1'b0};
                4:  v = '{SH_ROL, 64'h81, 1, 64'h03, 1'b0};
                5:  v = '{SH_SRL, 64'h10, 5, 64'h00, 1'b1};
                6:  v = '{SH_SLL, 64'hA5, 0, 64'hA5, 1'b0};
                7:  v = '{SH_SRA, 64'hA5, 0, 64'hA5, 1'b0};
                8:  v = '{SH_ROR, 64'h3C, 0, 64'h3C, 1'b0};
                9:  v = '{3'b010, 64'hC1, 1, 64'h82, 1'b1};
                10: v = '{3'b111, 64'h01, 1, 64'h80, 1'b0};
                11: v = '{3'b011, 64'h80, 7, 64'h40, 1'b0};
                default: v = '{SH_SLL, 64'h40, 2, 64'h00, 1'b1};
            endcase
        end
        return v;
    endfunction

    task automatic put(int d, logic v, logic [63:0] a, int n,
                       logic [2:0] op, logic [3:0] tag);
        if (d == 0) begin
            a_iv = v; a_a = a[31:0]; a_sh = n[4:0];
            a_op = op; a_tg = tag;
        end else begin
            b_iv = v; b_a = a[7:0]; b_sh = n[2:0];
            b_op = op; b_tg = tag;
        end
    endtask

    task automatic set_ordy(int d, logic r);
        if (d == 0) a_or = r;
        else b_or = r;
    endtask

    // Monitor: in_ready rule, held-output rule, pop/compare, push
    task automatic monitor(int d);
        obs_t  o;
        item_t e;
        o = obs(d);
        if (rst) begin
            qclear(d);
            hold_v[d] = 1'b0;
            return;
        end
        check(o.ir == ((qsize(d) < lat(d)) || o.ordy), "in_ready",
              64'(o.ir), 64'((qsize(d) < lat(d)) || o.ordy));
        if (hold_v[d]) begin
            check(o.ov && o.dat == held[d].dat && o.co == held[d].co
                  && o.tag == held[d].tag, "held_output",
                  o.dat, held[d].dat);
        end
        hold_v[d] = o.ov && !o.ordy;
        held[d]   = o;
        if (o.ov && o.ordy) begin
            check(qsize(d) != 0, "unexpected_result", 64'(o.tag), 0);
            if (qsize(d) != 0) begin
                e = qpop(d);
                check(o.dat == e.dat, "out_data", o.dat, e.dat);
                check(o.co == e.co, "out_cout", 64'(o.co), 64'(e.co));
                check(o.tag == e.tag, "out_tag", 64'(o.tag), 64'(e.tag));
                if (e.lat) begin
                    check(cyc - e.cyc == lat(d), "latency",
                          64'(cyc - e.cyc), 64'(lat(d)));
                end
            end
        end
        if (o.iv && o.ir) begin
            e = pend[d];
            e.cyc = cyc;
            qpush(d, e);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) monitor(d);
    end

    task automatic wait_accept(int d);
        bit   got;
        obs_t o;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            o = obs(d);
            got = o.ir;
            @(posedge clk);
            #1;
        end
        check(got, "accept_timeout", 64'(got), 64'd1);
    endtask

    task automatic wait_drain(int d);
        for (int k = 0; k < 200 && qsize(d) != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check(qsize(d) == 0, "drain", 64'(qsize(d)), 0);
    endtask

    task automatic random_ops(int d, int count);
        logic [63:0] a;
        logic [2:0]  op;
        logic [3:0]  tg;
        int          n, w, r;
        w = wid(d);
        for (int i = 0; i < count; i++) begin
            a  = {$urandom, $urandom};
            op = 3'($urandom);
            tg = 4'($urandom);
            r  = $urandom_range(0, 5);
            n  = (r == 0) ? 0 : (r == 1) ? w - 1 : $urandom_range(0, w - 1);
            pend[d] = model(w, a, n, op, tg);
            put(d, $urandom_range(0, 3) != 0, a, n, op, tg);
            set_ordy(d, $urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        put(d, 1'b0, 64'd0, 0, 3'd0, 4'd0);
        set_ordy(d, 1'b1);
        wait_drain(d);
    endtask

    task automatic run_dut(int d);
        obs_t        o;
        vec_t        v;
        logic [63:0] a;
        int          sent, w;
        bit          saw_stall;
        w = wid(d);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        o = obs(d);
        check(o.ov == 1'b0, "reset_out_valid", 64'(o.ov), 0);
        check(o.dat == 64'd0, "reset_out_data", o.dat, 0);
        check(o.co == 1'b0, "reset_out_cout", 64'(o.co), 0);
        check(o.tag == 4'd0, "reset_out_tag", 64'(o.tag), 0);
        check(o.ir == 1'b1, "reset_in_ready", 64'(o.ir), 1);
        @(posedge clk);
        #1;

        set_ordy(d, 1'b1);
        for (int i = 0; i < 13; i++) begin
            v = dir_vec(d, i);
            pend[d] = '{dat: v.r, co: v.c, tag: 4'(i), cyc: 0, lat: 1'b1};
            put(d, 1'b1, v.a, v.n, v.op, 4'(i));
            wait_accept(d);
            put(d, 1'b0, 64'd0, 0, 3'd0, 4'd0);
            wait_drain(d);
        end

        sent = 0;
        saw_stall = 1'b0;
        for (int j = 0; j < 60 && !(sent == 8 && qsize(d) == 0); j++) begin
            set_ordy(d, !(j >= 3 && j <= 9));
            if (sent < 8) begin
                a = {$urandom, $urandom};
                pend[d] = model(w, a, j % w, SH_SRA, 4'(sent));
                put(d, 1'b1, a, j % w, SH_SRA, 4'(sent));
            end else begin
                put(d, 1'b0, 64'd0, 0, 3'd0, 4'd0);
            end
            @(negedge clk);
            o = obs(d);
            if (o.iv && !o.ir) saw_stall = 1'b1;
            if (o.iv && o.ir) sent++;
            @(posedge clk);
            #1;
        end
        check(saw_stall, "bp_in_ready_drop", 64'(saw_stall), 1);
        check(sent == 8, "bp_all_sent", 64'(sent), 8);
        put(d, 1'b0, 64'd0, 0, 3'd0, 4'd0);
        set_ordy(d, 1'b1);
        wait_drain(d);

        random_ops(d, 300);

        set_ordy(d, 1'b0);
        for (int j = 0; j < 3; j++) begin
            a = {$urandom, $urandom};
            pend[d] = model(w, a, 1, SH_SLL, 4'(8 + j));
            put(d, 1'b1, a, 1, SH_SLL, 4'(8 + j));
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        put(d, 1'b0, 64'd0, 0, 3'd0, 4'd0);
        @(negedge clk);
        o = obs(d);
        check(o.ov == 1'b0, "flush_out_valid", 64'(o.ov), 0);
        check(o.ir == 1'b1, "flush_in_ready", 64'(o.ir), 1);
        @(posedge clk);
        #1;
        set_ordy(d, 1'b1);
        repeat (12) @(posedge clk);
        #1;

        random_ops(d, 60);
    endtask

    initial begin
        rst = 1'b1;
        put(0, 1'b0, 64'd0, 0, 3'd0, 4'd0);
        put(1, 1'b0, 64'd0, 0, 3'd0, 4'd0);
        set_ordy(0, 1'b1);
        set_ordy(1, 1'b1);
        for (int d = 0; d < NDUT; d++) begin
            pend[d] = '0;
            held[d] = '0;
            hold_v[d] = 1'b0;
        end
        for (int d = 0; d < NDUT; d++) run_dut(d);
        check(q0.size() == 0, "final_queue_a", 64'(q0.size()), 0);
        check(q1.size() == 0, "final_queue_b", 64'(q1.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
